// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM encoding and sizing helpers for the digit-serial multiplier
package mult_pkg;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_DONE = 3'd2
  } state_t;
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction
endpackage

// File: rtl/mult_seq_nxn_if.sv
// mult_seq_nxn_if: operand request and result handshake of the digit-serial multiplier
interface mult_seq_nxn_if #(parameter int WIDTH = 8);
  import mult_pkg::*;
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic busy;
  logic done_flag;
  logic [2*WIDTH-1:0] product;
  logic [ST_W-1:0] state_out;
  modport master(output start, signed_mode, dataa, datab, input busy, done_flag, product, state_out);
  modport slave(input start, signed_mode, dataa, datab, output busy, done_flag, product, state_out);
endinterface

// File: rtl/mult_digit.sv
// mult_digit: combinational DIGIT x DIGIT unsigned multiplier
module mult_digit #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0]   a,
  input  logic [DIGIT-1:0]   b,
  output logic [2*DIGIT-1:0] p
);
  assign p = (2*DIGIT)'(a) * (2*DIGIT)'(b);
endmodule

// File: rtl/mult_seq_nxn.sv
// mult_seq_nxn: WIDTH x WIDTH multiplier accumulating one DIGIT x DIGIT partial product per clock
module mult_seq_nxn import mult_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic reset_a,
  mult_seq_nxn_if.slave bus
);
  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int DW = $clog2(ND + 1);
  localparam int PW = 2 * WIDTH;
  state_t state, state_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic neg;
  logic [PW-1:0] acc, pp, sum, product;
  logic [DW-1:0] di, dj;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic [2*DIGIT-1:0] pd;
  logic last_i, last, launch;
  assign dig_a = a_mag[32'(di)*DIGIT +: DIGIT];
  assign dig_b = b_mag[32'(dj)*DIGIT +: DIGIT];
  mult_digit #(.DIGIT(DIGIT)) u_digit (.a(dig_a), .b(dig_b), .p(pd));
  assign pp = PW'(pd) << ((32'(di) + 32'(dj)) * DIGIT);
  assign sum = acc + pp;
  assign last_i = di == DW'(ND - 1);
  assign last = last_i && dj == DW'(ND - 1);
  assign launch = bus.start && (state == ST_IDLE || state == ST_DONE);
  always_comb begin
    state_n = launch ? ST_CALC :
              state == ST_CALC ? (last ? ST_DONE : ST_CALC) :
              (state == ST_IDLE || state == ST_DONE) ? state : ST_IDLE;
  end
  // Magnitudes are latched so the datapath stays unsigned; the sign is reapplied once at the end.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      state   <= ST_IDLE;
      product <= '0;
      acc     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      neg     <= 1'b0;
      di      <= '0;
      dj      <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        a_mag <= bus.signed_mode && bus.dataa[WIDTH-1] ? -bus.dataa : bus.dataa;
        b_mag <= bus.signed_mode && bus.datab[WIDTH-1] ? -bus.datab : bus.datab;
        neg   <= bus.signed_mode && (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
        acc   <= '0;
        di    <= '0;
        dj    <= '0;
      end else if (state == ST_CALC) begin
        acc <= sum;
        di  <= last_i ? '0 : di + 1'b1;
        dj  <= last_i ? dj + 1'b1 : dj;
        if (last) product <= neg ? -sum : sum;
      end
    end
  end
  assign bus.busy      = state == ST_CALC;
  assign bus.done_flag = state == ST_DONE;
  assign bus.product   = product;
  assign bus.state_out = state;
endmodule

// File: tb/tb_mult_seq_nxn.sv
// tb_mult_seq_nxn: scoreboard bench for 8- and 16-bit digit-serial multipliers against an integer model
module tb_mult_seq_nxn;
  import mult_pkg::*;
  logic clk = 1'b0;
  logic reset_a;
  always #5 clk = ~clk;
  mult_seq_nxn_if #(.WIDTH(8))  b8();
  mult_seq_nxn_if #(.WIDTH(16)) b16();
  mult_seq_nxn #(.WIDTH(8),  .DIGIT(4)) u8  (.clk(clk), .reset_a(reset_a), .bus(b8.slave));
  mult_seq_nxn #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .reset_a(reset_a), .bus(b16.slave));
  int checks = 0;
  int passed = 0;
  logic [63:0] q8[$];
  logic [63:0] q16[$];
  logic p8 = 1'b0, p16 = 1'b0;
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input bit s, input int w);
    longint sa, sb;
    sa = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic timeout(input string n);
    checks++;
    $display("FAIL %s: got timeout expected completion", n);
  endtask
  task automatic wait8();
    int n = 0;
    while (b8.busy && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("wait8");
  endtask
  task automatic wait16();
    int n = 0;
    while (b16.busy && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("wait16");
  endtask
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input bit s);
    wait8();
    b8.dataa = a; b8.datab = b; b8.signed_mode = s; b8.start = 1'b1;
    q8.push_back(model(64'(a), 64'(b), s, 8));
    tick();
    b8.start = 1'b0; b8.dataa = 8'($urandom); b8.datab = 8'($urandom); b8.signed_mode = 1'($urandom);
  endtask
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit s);
    wait16();
    b16.dataa = a; b16.datab = b; b16.signed_mode = s; b16.start = 1'b1;
    q16.push_back(model(64'(a), 64'(b), s, 16));
    tick();
    b16.start = 1'b0; b16.dataa = 16'($urandom); b16.datab = 16'($urandom); b16.signed_mode = 1'($urandom);
  endtask
  always @(negedge clk) begin
    if (!reset_a && b8.done_flag && !p8) begin
      if (q8.size() == 0) begin checks++; $display("FAIL prod8: got %0h expected none", b8.product); end
      else chk("prod8", 64'(b8.product), q8.pop_front());
    end
    if (!reset_a && b16.done_flag && !p16) begin
      if (q16.size() == 0) begin checks++; $display("FAIL prod16: got %0h expected none", b16.product); end
      else chk("prod16", 64'(b16.product), q16.pop_front());
    end
    p8 = b8.done_flag;
    p16 = b16.done_flag;
  end
  initial begin
    logic [7:0] a0, b0, a1, b1;
    bit s0, s1;
    int n;
    reset_a = 1'b1;
    b8.start = 0; b8.signed_mode = 0; b8.dataa = 0; b8.datab = 0;
    b16.start = 0; b16.signed_mode = 0; b16.dataa = 0; b16.datab = 0;
    tick(); tick();
    chk("rst_prod8", 64'(b8.product), 0);
    chk("rst_busy8", 64'(b8.busy), 0);
    chk("rst_done8", 64'(b8.done_flag), 0);
    chk("rst_state8", 64'(b8.state_out), 0);
    chk("rst_prod16", 64'(b16.product), 0);
    b8.start = 1'b1;
    tick();
    chk("rst_start_state", 64'(b8.state_out), 0);
    chk("rst_start_busy", 64'(b8.busy), 0);
    reset_a = 1'b0; b8.start = 1'b0;
    tick();
    chk("idle_state", 64'(b8.state_out), 0);
    b8.dataa = 8'hFF; b8.datab = 8'hFF; b8.signed_mode = 0; b8.start = 1'b1;
    q8.push_back(model(64'hFF, 64'hFF, 0, 8));
    tick();
    b8.start = 1'b0;
    chk("lat_state_calc", 64'(b8.state_out), 1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("lat_busy", 64'(b8.busy), 1);
    end
    tick();
    chk("lat_done", 64'(b8.done_flag), 1);
    chk("lat_busy_off", 64'(b8.busy), 0);
    chk("lat_state_done", 64'(b8.state_out), 2);
    chk("lat_prod", 64'(b8.product), 64'hFE01);
    start8(8'hFD, 8'h05, 1);
    start8(8'h80, 8'h80, 1);
    start8(8'h80, 8'h7F, 1);
    wait8();
    chk("signed_last", 64'(b8.product), 64'hC080);
    a0 = 8'($urandom); b0 = 8'($urandom); s0 = 1'($urandom);
    b8.dataa = a0; b8.datab = b0; b8.signed_mode = s0; b8.start = 1'b1;
    q8.push_back(model(64'(a0), 64'(b0), s0, 8));
    tick();
    for (int c = 0; c < 3; c++) begin
      b8.dataa = 8'($urandom); b8.datab = 8'($urandom); b8.signed_mode = 1'($urandom);
      tick();
    end
    a1 = 8'($urandom); b1 = 8'($urandom); s1 = 1'($urandom);
    b8.dataa = a1; b8.datab = b1; b8.signed_mode = s1;
    tick();
    chk("held_done", 64'(b8.done_flag), 1);
    q8.push_back(model(64'(a1), 64'(b1), s1, 8));
    tick();
    chk("b2b_busy", 64'(b8.busy), 1);
    b8.start = 1'b0;
    wait8();
    b8.dataa = 8'h12; b8.datab = 8'h34; b8.signed_mode = 0; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("abort_state", 64'(b8.state_out), 0);
    chk("abort_prod", 64'(b8.product), 0);
    chk("abort_done", 64'(b8.done_flag), 0);
    start8(8'h12, 8'h34, 0);
    wait8();
    chk("after_abort", 64'(b8.product), 64'h03A8);
    b16.dataa = 16'hFFFF; b16.datab = 16'hFFFF; b16.signed_mode = 0; b16.start = 1'b1;
    q16.push_back(model(64'hFFFF, 64'hFFFF, 0, 16));
    tick();
    b16.start = 1'b0;
    n = 0;
    while (b16.busy && n < 40) begin tick(); n++; end
    chk("lat16", 64'(n), 16);
    chk("prod16_max", 64'(b16.product), 64'hFFFE0001);
    start16(16'h8000, 16'hFFFF, 1);
    wait16();
    chk("prod16_signed", 64'(b16.product), 64'h00008000);
    for (int i = 0; i < 20; i++) begin
      start8(8'($urandom), 8'($urandom), 1'($urandom));
      start16(16'($urandom), 16'($urandom), 1'($urandom));
    end
    wait8();
    wait16();
    tick(); tick();
    chk("drain8", 64'(q8.size()), 0);
    chk("drain16", 64'(q16.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
